port_wr_sgdma: RTL and testbench
================================

PORT_WR_SGDMA -- requirements
Module: port_wr_sgdma

Parameters
REQ-001 FIFO_DEPTH, default 16: input word FIFO depth, power of two.
REQ-002 MAX_WORDS, default 64: maximum words per packet before forced termination.
REQ-003 TO_LIMIT, default 255: ready-wait timeout in cycles (used only with the timeout option).

Interface
REQ-004 i_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_dat_vld  in  1  input word valid.
REQ-007 i_dat  in  `DATA_DWIDTH  input word.
REQ-008 i_dat_sop / i_dat_eop  in  1 each  first / last word of packet.
REQ-009 o_dat_rdy  out  1  FIFO can accept a word.
REQ-010 i_base_vld  in  1  page base address offered.
REQ-011 i_base_addr  in  `ADDR_WIDTH  base address of allocated page.
REQ-012 o_base_rdy  out  1  one-cycle pulse, base address consumed.
REQ-013 o_mmu_wr_req  out  1  write request to MMU.
REQ-014 o_mmu_wr_addr  out  `ADDR_WIDTH  write address.
REQ-015 o_mmu_wr_dat  out  `DATA_DWIDTH  write data.
REQ-016 i_mmu_wr_ready  in  1  MMU accepts; a transfer occurs in a cycle with req and ready both high.
REQ-017 o_pkt_done  out  1  one-cycle pulse at packet end.
REQ-018 o_pkt_len  out  7  words written for the finished packet; valid with o_pkt_done.
REQ-019 o_err  out  1  one-cycle pulse: truncation, orphan word or timeout.
REQ-020 o_busy  out  1  high in any state other than IDLE.

Function
REQ-021 Input FIFO: word written when i_dat_vld and o_dat_rdy; o_dat_rdy = not full; simultaneous push and pop when full is disallowed by o_dat_rdy; when empty, a pushed word is not poppable until the next cycle.
REQ-022 FSM states: IDLE, ADDR, XFER, DONE, DRAIN.
REQ-023 IDLE: FIFO head with sop -> ADDR; FIFO head without sop is popped and discarded, o_err pulses, stay IDLE.
REQ-024 ADDR: on i_base_vld, latch base, pulse o_base_rdy, clear word index -> XFER.
REQ-025 XFER: o_mmu_wr_req high while FIFO non-empty; addr = base + index, modulo 2^`ADDR_WIDTH (wraps silently); dat = FIFO head.
REQ-026 req, addr and dat are held stable until the transfer; transfer pops FIFO and increments index.
REQ-027 Back-to-back: if ready stays high and the next word is present, the next transfer occurs in the next cycle.
REQ-028 FIFO empty mid-packet: req deasserts, state stays XFER.
REQ-029 Transfer of the eop word -> DONE.
REQ-030 Transfer of word MAX_WORDS without eop: pulse o_err -> DRAIN.
REQ-031 DRAIN: pop and discard until the eop word is popped -> DONE; no requests issued.
REQ-032 DONE: one cycle; pulse o_pkt_done, o_pkt_len = index -> IDLE.
REQ-033 sop arriving inside a packet (XFER) is treated as an ordinary data word.

Reset
REQ-034 Reset while i_rst is high at a clock edge: FSM to IDLE, FIFO emptied, index and base cleared.
REQ-035 Reset output values: o_mmu_wr_req, o_base_rdy, o_pkt_done, o_err, o_busy = 0; o_mmu_wr_addr, o_mmu_wr_dat, o_pkt_len = 0; o_dat_rdy = 0 during reset, 1 on the first cycle after.
REQ-036 Reset mid-packet abandons the packet with no o_pkt_done.

Configuration
REQ-037 With macro PORT_WR_TIMEOUT_EN defined: an 8-bit counter counts cycles with req high and ready low, cleared on each transfer. At TO_LIMIT: pulse o_err, drop req -> DRAIN. The word at the FIFO head is not written.
REQ-038 Without PORT_WR_TIMEOUT_EN: no counter; XFER waits on ready indefinitely.

Verification
REQ-039 Four-word packet (sop..eop), base 0x100, ready registered one cycle after req -> writes to 0x100..0x103 in order; o_pkt_done with o_pkt_len = 4; exactly one o_base_rdy.
REQ-040 Base 2^`ADDR_WIDTH-2, three-word packet -> addresses MAX-1, MAX, 0.
REQ-041 70-word packet, MAX_WORDS = 64 -> 64 writes, o_err, remaining 6 words drained, o_pkt_len = 64.
REQ-042 Word without sop while IDLE -> discarded, o_err pulse, no request; next good packet is handled normally.
REQ-043 Ready held low with PORT_WR_TIMEOUT_EN defined -> o_err 255 cycles after req rises, packet drained. Without the macro -> req stays high after 300 cycles.
REQ-044 i_rst asserted at the 2nd word of an 8-word packet -> all outputs at reset values next cycle; no o_pkt_done; next packet starts cleanly.

Source files
------------

// File: rtl/port_wr_sgdma.sv
// port_wr_sgdma: buffers packet words in a small FIFO and writes them to an MMU
// page, one word per address starting at an externally supplied base address.
// Packets longer than MAX_WORDS are truncated and the tail is drained.
// Optional ready-wait timeout enabled by defining PORT_WR_TIMEOUT_EN.
`timescale 1ns/1ps

`ifndef DATA_DWIDTH
`define DATA_DWIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module port_wr_sgdma #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_WORDS  = 64,
    parameter int TO_LIMIT   = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_dat_vld,
    input  logic [`DATA_DWIDTH-1:0] i_dat,
    input  logic                    i_dat_sop,
    input  logic                    i_dat_eop,
    output logic                    o_dat_rdy,
    input  logic                    i_base_vld,
    input  logic [`ADDR_WIDTH-1:0]  i_base_addr,
    output logic                    o_base_rdy,
    output logic                    o_mmu_wr_req,
    output logic [`ADDR_WIDTH-1:0]  o_mmu_wr_addr,
    output logic [`DATA_DWIDTH-1:0] o_mmu_wr_dat,
    input  logic                    i_mmu_wr_ready,
    output logic                    o_pkt_done,
    output logic [6:0]              o_pkt_len,
    output logic                    o_err,
    output logic                    o_busy
);

    localparam int DW = `DATA_DWIDTH;
    localparam int AW = `ADDR_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [6:0] LAST_IDX = 7'(MAX_WORDS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, XFER, DONE, DRAIN} state_t;

    state_t state;

    // FIFO entry: {sop, eop, data}
    logic [DW+1:0] mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [DW+1:0] head;
    logic          head_sop;
    logic          head_eop;
    logic [DW-1:0] head_dat;

    logic [AW-1:0] base;
    logic [6:0]    idx;
    logic          err_q;
    logic          req;
    logic          xfer;

`ifdef PORT_WR_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TO_LIMIT - 1);
    logic [7:0] to_cnt;
`endif

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign o_dat_rdy = !full && !i_rst;
    assign push     = i_dat_vld && o_dat_rdy;

    assign head     = mem[rd_ptr[PW-1:0]];
    assign head_sop = head[DW+1];
    assign head_eop = head[DW];
    assign head_dat = head[DW-1:0];

    // Storage array write port.
    // NOTE: the data array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= {i_dat_sop, i_dat_eop, i_dat};
        end
    end

    // FIFO pointer update; a word pushed into an empty FIFO is only visible next cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    // Request is a decode of registered state and FIFO occupancy, so it stays
    // stable (with address and data) until the MMU takes the word.
    assign req  = (state == XFER) && !empty;
    assign xfer = req && i_mmu_wr_ready;

    assign o_mmu_wr_req  = req;
    assign o_mmu_wr_addr = base + AW'(idx);
    assign o_mmu_wr_dat  = req ? head_dat : '0;

    assign o_base_rdy = (state == ADDR) && i_base_vld;
    assign o_pkt_done = (state == DONE);
    assign o_pkt_len  = (state == DONE) ? idx : 7'd0;
    assign o_err      = err_q;
    assign o_busy     = (state != IDLE);

    // FIFO pop decision per state.
    always_comb begin
        // NOTE: default first so no path through the case leaves pop unassigned (no latch).
        pop = 1'b0;
        case (state)
            IDLE:    pop = !empty && !head_sop;
            XFER:    pop = xfer;
            DRAIN:   pop = !empty;
            default: pop = 1'b0;
        endcase
    end

    // Packet sequencing FSM with registered error pulse, base and word index.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            base  <= '0;
            idx   <= '0;
            err_q <= 1'b0;
`ifdef PORT_WR_TIMEOUT_EN
            to_cnt <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (head_sop) begin
                            state <= ADDR;
                        end else begin
                            // Orphan word: popped by the comb block, flagged here.
                            err_q <= 1'b1;
                        end
                    end
                end

                ADDR: begin
                    if (i_base_vld) begin
                        base  <= i_base_addr;
                        idx   <= '0;
                        state <= XFER;
                    end
                end

                XFER: begin
                    if (xfer) begin
                        idx <= idx + 7'd1;
`ifdef PORT_WR_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                        if (head_eop) begin
                            state <= DONE;
                        end else if (idx == LAST_IDX) begin
                            err_q <= 1'b1;
                            state <= DRAIN;
                        end
                    end
`ifdef PORT_WR_TIMEOUT_EN
                    else if (req) begin
                        // Request pending with ready low: give up after TO_LIMIT cycles,
                        // leaving the head word unwritten for DRAIN to discard.
                        if (to_cnt == TO_LAST) begin
                            to_cnt <= '0;
                            err_q  <= 1'b1;
                            state  <= DRAIN;
                        end else begin
                            to_cnt <= to_cnt + 8'd1;
                        end
                    end
`endif
                end

                DRAIN: begin
                    if (!empty && head_eop) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_port_wr_sgdma.sv
// tb_port_wr_sgdma: directed self-checking bench for port_wr_sgdma.
`timescale 1ns/1ps

`ifndef DATA_DWIDTH
`define DATA_DWIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module tb_port_wr_sgdma;

    localparam int DW = `DATA_DWIDTH;
    localparam int AW = `ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_dat_vld;
    logic [DW-1:0] i_dat;
    logic          i_dat_sop;
    logic          i_dat_eop;
    logic          o_dat_rdy;
    logic          i_base_vld;
    logic [AW-1:0] i_base_addr;
    logic          o_base_rdy;
    logic          o_mmu_wr_req;
    logic [AW-1:0] o_mmu_wr_addr;
    logic [DW-1:0] o_mmu_wr_dat;
    logic          i_mmu_wr_ready;
    logic          o_pkt_done;
    logic [6:0]    o_pkt_len;
    logic          o_err;
    logic          o_busy;

    always #5 clk = ~clk;

    port_wr_sgdma dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_dat_vld      (i_dat_vld),
        .i_dat          (i_dat),
        .i_dat_sop      (i_dat_sop),
        .i_dat_eop      (i_dat_eop),
        .o_dat_rdy      (o_dat_rdy),
        .i_base_vld     (i_base_vld),
        .i_base_addr    (i_base_addr),
        .o_base_rdy     (o_base_rdy),
        .o_mmu_wr_req   (o_mmu_wr_req),
        .o_mmu_wr_addr  (o_mmu_wr_addr),
        .o_mmu_wr_dat   (o_mmu_wr_dat),
        .i_mmu_wr_ready (i_mmu_wr_ready),
        .o_pkt_done     (o_pkt_done),
        .o_pkt_len      (o_pkt_len),
        .o_err          (o_err),
        .o_busy         (o_busy)
    );

    int total = 0;
    int bad   = 0;

    // Observed traffic, collected on the falling edge.
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            base_cnt = 0;
    int            done_cnt = 0;
    int            err_cnt  = 0;
    logic [6:0]    last_len = '0;
    int            cyc      = 0;
    int            rise_cyc = -1;
    int            err_cyc  = -1;
    logic          req_prev = 1'b0;
    logic          req_seen = 1'b0;
    logic          base_taken = 1'b0;
    int            rdy_mode = 0;  // 0: ready low, 1: ready = req one cycle late, 2: ready high

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: sample outputs mid-cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!i_rst) begin
            if (o_mmu_wr_req && i_mmu_wr_ready) begin
                wa_q.push_back(o_mmu_wr_addr);
                wd_q.push_back(o_mmu_wr_dat);
            end
            if (o_base_rdy) begin
                base_cnt++;
                base_taken = 1'b1;
            end
            if (o_pkt_done) begin
                done_cnt++;
                last_len = o_pkt_len;
            end
            if (o_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (o_mmu_wr_req && !req_prev) rise_cyc = cyc;
        end
        req_prev = o_mmu_wr_req;
        req_seen = o_mmu_wr_req;
    end

    // Responder: drives ready and retires the base offer just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (base_taken) begin
            i_base_vld = 1'b0;
            base_taken = 1'b0;
        end
        case (rdy_mode)
            0:       i_mmu_wr_ready = 1'b0;
            1:       i_mmu_wr_ready = req_seen;
            default: i_mmu_wr_ready = 1'b1;
        endcase
    end

    task automatic push_word(input logic [DW-1:0] d, input logic s, input logic e);
        int w;
        i_dat_vld = 1'b1;
        i_dat     = d;
        i_dat_sop = s;
        i_dat_eop = e;
        w = 0;
        @(negedge clk);
        while (!o_dat_rdy && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) check("push_accept", 64'(o_dat_rdy), 64'd1);
        @(posedge clk);
        #1;
        i_dat_vld = 1'b0;
    endtask

    task automatic send_pkt(input logic [AW-1:0] b, input int n, input logic [DW-1:0] d0);
        i_base_addr = b;
        i_base_vld  = 1'b1;
        for (int i = 0; i < n; i++) begin
            push_word(d0 + DW'(i), i == 0, i == n - 1);
        end
    endtask

    task automatic wait_done(input int target, input string tag);
        int w;
        w = 0;
        while (done_cnt < target && w < 2000) begin
            @(posedge clk);
            #2;
            w++;
        end
        check(tag, 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic clear_obs();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag, input logic rdy_exp);
        check({tag, "_dat_rdy"}, 64'(o_dat_rdy), 64'(rdy_exp));
        check({tag, "_req"},     64'(o_mmu_wr_req), 64'd0);
        check({tag, "_base_rdy"},64'(o_base_rdy), 64'd0);
        check({tag, "_done"},    64'(o_pkt_done), 64'd0);
        check({tag, "_err"},     64'(o_err), 64'd0);
        check({tag, "_busy"},    64'(o_busy), 64'd0);
        check({tag, "_addr"},    64'(o_mmu_wr_addr), 64'd0);
        check({tag, "_dat"},     64'(o_mmu_wr_dat), 64'd0);
        check({tag, "_len"},     64'(o_pkt_len), 64'd0);
    endtask

    initial begin
        int err0;
        int done0;
        i_rst          = 1'b1;
        i_dat_vld      = 1'b0;
        i_dat          = '0;
        i_dat_sop      = 1'b0;
        i_dat_eop      = 1'b0;
        i_base_vld     = 1'b0;
        i_base_addr    = '0;
        i_mmu_wr_ready = 1'b0;

        // Reset values while reset is held, then ready on the first cycle after.
        repeat (3) @(negedge clk);
        check_reset_outputs("rst", 1'b0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        @(negedge clk);
        check("rst_rdy_after", 64'(o_dat_rdy), 64'd1);
        @(posedge clk);
        #1;

        // Four-word packet, base 0x100, ready one cycle behind req.
        clear_obs();
        rdy_mode = 1;
        send_pkt(16'h0100, 4, 32'hA0);
        wait_done(1, "p4_done");
        check("p4_nwr", 64'(wa_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("p4_addr%0d", i), 64'(wa_q[i]), 64'h100 + 64'(i));
            check($sformatf("p4_dat%0d", i),  64'(wd_q[i]), 64'hA0 + 64'(i));
        end
        check("p4_len", 64'(last_len), 64'd4);
        check("p4_base_rdy", 64'(base_cnt), 64'd1);
        check("p4_err", 64'(err_cnt), 64'd0);

        // Address wrap at the top of the address space.
        clear_obs();
        rdy_mode = 2;
        send_pkt(16'hFFFE, 3, 32'hB0);
        wait_done(2, "wrap_done");
        check("wrap_nwr", 64'(wa_q.size()), 64'd3);
        check("wrap_addr0", 64'(wa_q[0]), 64'hFFFE);
        check("wrap_addr1", 64'(wa_q[1]), 64'hFFFF);
        check("wrap_addr2", 64'(wa_q[2]), 64'h0000);
        check("wrap_dat2",  64'(wd_q[2]), 64'hB2);
        check("wrap_len",   64'(last_len), 64'd3);

        // 70-word packet truncated at 64 words, tail drained.
        clear_obs();
        send_pkt(16'h1000, 70, 32'h1000_0000);
        wait_done(3, "trunc_done");
        check("trunc_nwr",    64'(wa_q.size()), 64'd64);
        check("trunc_addr0",  64'(wa_q[0]), 64'h1000);
        check("trunc_addr63", 64'(wa_q[63]), 64'h103F);
        check("trunc_dat63",  64'(wd_q[63]), 64'h1000_003F);
        check("trunc_err",    64'(err_cnt), 64'd1);
        check("trunc_len",    64'(last_len), 64'd64);
        repeat (3) @(posedge clk);
        #2;
        check("trunc_idle", 64'(o_busy), 64'd0);

        // Orphan word without sop while idle, then a normal packet.
        clear_obs();
        err0 = err_cnt;
        push_word(32'h55, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #2;
        check("orph_err",  64'(err_cnt - err0), 64'd1);
        check("orph_nwr",  64'(wa_q.size()), 64'd0);
        check("orph_busy", 64'(o_busy), 64'd0);
        check("orph_done", 64'(done_cnt), 64'd3);
        send_pkt(16'h0300, 2, 32'hC0);
        wait_done(4, "orph_next_done");
        check("orph_next_nwr",  64'(wa_q.size()), 64'd2);
        check("orph_next_addr", 64'(wa_q[1]), 64'h301);
        check("orph_next_len",  64'(last_len), 64'd2);

        // Ready held low.
        clear_obs();
        rdy_mode = 0;
        rise_cyc = -1;
        err0 = err_cnt;
        send_pkt(16'h0400, 1, 32'hD0);
        begin
            int w;
            w = 0;
            while (rise_cyc < 0 && w < 100) begin
                @(posedge clk);
                #2;
                w++;
            end
        end
        check("to_req_rise", 64'(rise_cyc >= 0), 64'd1);
`ifdef PORT_WR_TIMEOUT_EN
        begin
            int w;
            w = 0;
            while (err_cnt == err0 && w < 400) begin
                @(posedge clk);
                #2;
                w++;
            end
        end
        check("to_err_seen", 64'(err_cnt - err0), 64'd1);
        check("to_err_delay", 64'(err_cyc - rise_cyc), 64'd255);
        wait_done(5, "to_done");
        check("to_nwr", 64'(wa_q.size()), 64'd0);
        check("to_len", 64'(last_len), 64'd0);
`else
        repeat (300) @(posedge clk);
        #2;
        check("to_req_held", 64'(o_mmu_wr_req), 64'd1);
        check("to_busy",     64'(o_busy), 64'd1);
        check("to_no_err",   64'(err_cnt - err0), 64'd0);
        rdy_mode = 2;
        wait_done(5, "to_done");
        check("to_nwr",  64'(wa_q.size()), 64'd1);
        check("to_addr", 64'(wa_q[0]), 64'h400);
        check("to_len",  64'(last_len), 64'd1);
`endif

        // Reset at the second word of an eight-word packet.
        clear_obs();
        rdy_mode = 1;
        done0 = done_cnt;
        i_base_addr = 16'h0500;
        i_base_vld  = 1'b1;
        push_word(32'hE0, 1'b1, 1'b0);
        push_word(32'hE1, 1'b0, 1'b0);
        i_rst      = 1'b1;
        i_base_vld = 1'b0;
        base_taken = 1'b0;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("mrst", 1'b1);
        repeat (5) @(posedge clk);
        #2;
        check("mrst_no_done", 64'(done_cnt), 64'(done0));
        clear_obs();
        send_pkt(16'h0600, 3, 32'hF0);
        wait_done(done0 + 1, "mrst_next_done");
        check("mrst_next_nwr",   64'(wa_q.size()), 64'd3);
        check("mrst_next_addr0", 64'(wa_q[0]), 64'h600);
        check("mrst_next_addr2", 64'(wa_q[2]), 64'h602);
        check("mrst_next_dat2",  64'(wd_q[2]), 64'hF2);
        check("mrst_next_len",   64'(last_len), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
